cond_exec_unit: RTL and testbench

Parametrised successor to the processor's single-cycle condition checker. Holds NUM_BANKS NZCV flag registers with partial flag-write enables. Evaluates the 4-bit ARM condition field against a selected bank. Adds an IT-block sequencer (up to 4 predicated instructions), an NV/undefined-condition trap and an optional registered output stage. Sits between decode and the register-file/memory write enables.

---
 rtl/cond_pkg.sv | 50 +++++
 rtl/it_sequencer.sv | 83 ++++++++
 rtl/cond_exec_unit.sv | 99 +++++++++
 tb/tb_cond_exec_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types and the ARM condition-pass function for the conditional execution unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'ha, LT = 4'hb,
    GT = 4'hc, LE = 4'hd, AL = 4'he, NV = 4'hf
  } cond_e;

  typedef enum logic [0:0] {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  function automatic logic cond_pass(cond_e c, logic [3:0] f);
    logic n, z, cf, v;
    logic res;
    n  = f[N_IDX];
    z  = f[Z_IDX];
    cf = f[C_IDX];
    v  = f[V_IDX];
    res = 1'b0;
    case (c)
      EQ: res = z;
      NE: res = !z;
      CS: res = cf;
      CC: res = !cf;
      MI: res = n;
      PL: res = !n;
      VS: res = v;
      VC: res = !v;
      HI: res = cf && !z;
      LS: res = !cf || z;
      GE: res = (n == v);
      LT: res = (n != v);
      GT: res = !z && (n == v);
      LE: res = z || (n != v);
      AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/it_sequencer.sv
// IT-block sequencer: tracks up to four predicated slots and produces the effective condition.
module it_sequencer
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] cond,
  input  logic       it_start,
  input  logic [3:0] it_first,
  input  logic [2:0] it_mask,
  input  logic [1:0] it_len,
  input  logic       flush,
  output cond_e      eff_cond,
  output logic       it_active,
  output logic       it_err
);

  it_state_e  state_q, state_d;
  logic [3:0] first_q, first_d;
  logic [3:0] pat_q, pat_d;
  logic [2:0] cnt_q, cnt_d;
  logic       start_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IT_IDLE;
      first_q <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  // AL/NV firstcond cannot have an else slot, so multi-slot blocks on them are rejected.
  assign start_bad = (it_first[3:1] == 3'b111) && (it_len != 2'd0);
  assign it_active = (state_q == IT_ACTIVE);

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    it_err   = 1'b0;
    eff_cond = cond_e'(cond);
    unique case (state_q)
      IT_IDLE: begin
        // The IT instruction itself always executes.
        if (it_start) eff_cond = AL;
        if (valid && it_start) begin
          if (start_bad) begin
            it_err = 1'b1;
          end else begin
            state_d = IT_ACTIVE;
            first_d = it_first;
            pat_d   = {it_mask, 1'b1};
            cnt_d   = {1'b0, it_len} + 3'd1;
          end
        end
      end
      IT_ACTIVE: begin
        eff_cond = cond_e'({first_q[3:1], first_q[0] ^ ~pat_q[0]});
        if (valid) begin
          it_err = it_start;
          pat_d  = pat_q >> 1;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IT_IDLE;
        end
      end
      default: state_d = IT_IDLE;
    endcase
    if (flush) begin
      state_d = IT_IDLE;
      cnt_d   = '0;
      pat_d   = '0;
    end
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional execution unit: banked NZCV flags, condition evaluation, IT sequencing, output stage.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned PIPE_OUT  = 0,
  parameter int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [3:0]        cond,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [3:0]        alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              it_start,
  input  logic [3:0]        it_first,
  input  logic [2:0]        it_mask,
  input  logic [1:0]        it_len,
  input  logic              flush,
  output logic              cond_ex,
  output logic [3:0]        flags_out,
  output logic              it_active,
  output logic              illegal_cond,
  output logic              it_err
);

  logic [3:0] bank_q [NUM_BANKS];
  logic [3:0] flags_cur;
  logic       in_range;
  cond_e      eff_cond;
  logic       seq_err;
  logic       cond_ex_c, illegal_c;

  it_sequencer u_seq (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .cond      (cond),
    .it_start  (it_start),
    .it_first  (it_first),
    .it_mask   (it_mask),
    .it_len    (it_len),
    .flush     (flush),
    .eff_cond  (eff_cond),
    .it_active (it_active),
    .it_err    (seq_err)
  );

  assign in_range = (32'(bank_sel) < NUM_BANKS);

  // Out-of-range selects fall back to bank 0.
  always_comb begin
    flags_cur = bank_q[0];
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (in_range && (bank_sel == BANK_W'(i))) flags_cur = bank_q[i];
    end
  end

  assign flags_out = flags_cur;
  assign cond_ex_c = valid && cond_pass(eff_cond, flags_cur);
  assign illegal_c = valid && (eff_cond == NV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= '0;
    end else if (cond_ex_c && in_range) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (bank_sel == BANK_W'(i)) begin
          if (flag_w[1]) bank_q[i][3:2] <= alu_flags[3:2];
          if (flag_w[0]) bank_q[i][1:0] <= alu_flags[1:0];
        end
      end
    end
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic cond_ex_q, illegal_q, it_err_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cond_ex_q <= 1'b0;
        illegal_q <= 1'b0;
        it_err_q  <= 1'b0;
      end else begin
        cond_ex_q <= cond_ex_c;
        illegal_q <= illegal_c;
        it_err_q  <= seq_err;
      end
    end
    assign cond_ex      = cond_ex_q;
    assign illegal_cond = illegal_q;
    assign it_err       = it_err_q;
  end else begin : g_comb
    assign cond_ex      = cond_ex_c;
    assign illegal_cond = illegal_c;
    assign it_err       = seq_err;
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed self-checking bench for cond_exec_unit (combinational and registered output variants).
module tb_cond_exec_unit;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_MI = 4'h4;
  localparam logic [3:0] C_VS = 4'h6, C_GE = 4'ha, C_LT = 4'hb, C_AL = 4'he, C_NV = 4'hf;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] cond = 4'h0;
  logic [0:0] bank_sel = 1'b0;
  logic [3:0] alu_flags = 4'h0;
  logic [1:0] flag_w = 2'b00;
  logic       it_start = 1'b0;
  logic [3:0] it_first = 4'h0;
  logic [2:0] it_mask = 3'b000;
  logic [1:0] it_len = 2'd0;
  logic       flush = 1'b0;

  logic       c_ex, c_ita, c_ill, c_err;
  logic [3:0] c_fl;
  logic       p_ex, p_ita, p_ill, p_err;
  logic [3:0] p_fl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cond_exec_unit #(.NUM_BANKS(2), .PIPE_OUT(0)) dut (
    .clk(clk), .reset(reset), .valid(valid), .cond(cond), .bank_sel(bank_sel),
    .alu_flags(alu_flags), .flag_w(flag_w), .it_start(it_start), .it_first(it_first),
    .it_mask(it_mask), .it_len(it_len), .flush(flush), .cond_ex(c_ex), .flags_out(c_fl),
    .it_active(c_ita), .illegal_cond(c_ill), .it_err(c_err)
  );

  cond_exec_unit #(.NUM_BANKS(2), .PIPE_OUT(1)) dut_p (
    .clk(clk), .reset(reset), .valid(valid), .cond(cond), .bank_sel(bank_sel),
    .alu_flags(alu_flags), .flag_w(flag_w), .it_start(it_start), .it_first(it_first),
    .it_mask(it_mask), .it_len(it_len), .flush(flush), .cond_ex(p_ex), .flags_out(p_fl),
    .it_active(p_ita), .illegal_cond(p_ill), .it_err(p_err)
  );

  // Present one cycle of inputs at the falling edge; outputs are sampled 2ns later.
  task automatic ins(input logic v, input logic [3:0] c, input logic bs,
                     input logic [3:0] alu, input logic [1:0] fw,
                     input logic its = 1'b0, input logic fl = 1'b0);
    @(negedge clk);
    valid = v; cond = c; bank_sel = bs; alu_flags = alu; flag_w = fw;
    it_start = its; flush = fl;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL rst_cond_ex got %b want 0", c_ex); end
    total++; if (c_fl !== 4'h0) begin bad++; $display("FAIL rst_flags got %h want 0", c_fl); end
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL rst_it_active got %b want 0", c_ita); end
    total++;
    if ({c_ill, c_err, p_ex, p_ill, p_err} !== 5'b0) begin
      bad++; $display("FAIL rst_pulses got %b want 00000", {c_ill, c_err, p_ex, p_ill, p_err});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_set_flags();
    ins(1, C_EQ, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL eq_after_reset got %b want 0", c_ex); end
    ins(1, C_AL, 0, 4'b0100, 2'b11);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL adds_al got %b want 1", c_ex); end
    ins(1, C_EQ, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL eq_after_adds got %b want 1", c_ex); end
    total++; if (c_fl !== 4'b0100) begin bad++; $display("FAIL flags_after_adds got %h want 4", c_fl); end
  endtask

  task automatic test_partial();
    ins(1, C_AL, 0, 4'b1111, 2'b11);
    ins(1, C_AL, 0, 4'b0000, 2'b01);
    total++; if (c_fl !== 4'b1111) begin bad++; $display("FAIL pre_update got %h want f", c_fl); end
    ins(1, C_GE, 0, 4'h0, 2'b00);
    total++; if (c_fl !== 4'b1100) begin bad++; $display("FAIL partial_cv got %h want c", c_fl); end
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL ge_nv got %b want 0", c_ex); end
    ins(1, C_LT, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL lt_nv got %b want 1", c_ex); end
    // A failing instruction must not write its flags.
    ins(1, C_NE, 0, 4'h0, 2'b11);
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL ne_z1 got %b want 0", c_ex); end
    ins(1, C_MI, 0, 4'h0, 2'b00);
    total++; if (c_fl !== 4'b1100) begin bad++; $display("FAIL no_upd_on_fail got %h want c", c_fl); end
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL mi_n1 got %b want 1", c_ex); end
  endtask

  task automatic test_banks();
    ins(1, C_AL, 0, 4'b0000, 2'b11);
    ins(1, C_AL, 1, 4'b0010, 2'b11);
    ins(1, C_CS, 1, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL cs_bank1 got %b want 1", c_ex); end
    total++; if (c_fl !== 4'b0010) begin bad++; $display("FAIL flags_bank1 got %h want 2", c_fl); end
    ins(1, C_CS, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL cs_bank0 got %b want 0", c_ex); end
    total++; if (c_fl !== 4'b0000) begin bad++; $display("FAIL flags_bank0 got %h want 0", c_fl); end
  endtask

  task automatic test_it_block();
    logic [3:0] exp_ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    ins(1, C_AL, 0, 4'b0100, 2'b11);
    it_first = C_EQ; it_mask = 3'b010; it_len = 2'd3;
    ins(1, C_NV, 0, 4'h0, 2'b00, 1'b1);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL it_instr_exec got %b want 1", c_ex); end
    total++; if (c_ill !== 1'b0) begin bad++; $display("FAIL it_instr_ill got %b want 0", c_ill); end
    for (int s = 0; s < 4; s++) begin
      ins(1, C_NV, 0, 4'h0, 2'b00);
      total++;
      if (c_ex !== exp_ex[s][0]) begin
        bad++; $display("FAIL it_slot%0d got %b want %b", s, c_ex, exp_ex[s][0]);
      end
      total++; if (c_ita !== 1'b1) begin bad++; $display("FAIL it_act_slot%0d got %b want 1", s, c_ita); end
      if (s == 1) begin
        ins(0, C_NV, 0, 4'h0, 2'b00);
        total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL it_stall got %b want 0", c_ex); end
      end
    end
    ins(1, C_EQ, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL it_done got %b want 0", c_ita); end
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL after_it_own got %b want 1", c_ex); end
  endtask

  task automatic test_errors();
    ins(1, C_NV, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL nv_exec got %b want 0", c_ex); end
    total++; if (c_ill !== 1'b1) begin bad++; $display("FAIL nv_illegal got %b want 1", c_ill); end
    it_first = C_EQ; it_mask = 3'b000; it_len = 2'd2;
    ins(1, C_AL, 0, 4'h0, 2'b00, 1'b1);
    ins(1, C_AL, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL err_slot0 got %b want 1", c_ex); end
    it_first = C_AL; it_len = 2'd3;
    ins(1, C_AL, 0, 4'h0, 2'b00, 1'b1);
    total++; if (c_err !== 1'b1) begin bad++; $display("FAIL it_in_active_err got %b want 1", c_err); end
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL it_in_active_ex got %b want 0", c_ex); end
    ins(1, C_AL, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b1) begin bad++; $display("FAIL last_slot_act got %b want 1", c_ita); end
    total++; if (c_err !== 1'b0) begin bad++; $display("FAIL err_pulse_end got %b want 0", c_err); end
    ins(1, C_AL, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL count_kept got %b want 0", c_ita); end
    it_first = C_AL; it_len = 2'd2;
    ins(1, C_NV, 0, 4'h0, 2'b00, 1'b1);
    total++; if (c_err !== 1'b1) begin bad++; $display("FAIL al_len2_err got %b want 1", c_err); end
    ins(1, C_AL, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL al_len2_idle got %b want 0", c_ita); end
  endtask

  task automatic test_flush();
    it_first = C_EQ; it_mask = 3'b111; it_len = 2'd3;
    ins(1, C_AL, 0, 4'h0, 2'b00, 1'b1);
    ins(1, C_NV, 0, 4'h0, 2'b00);
    ins(1, C_NV, 0, 4'b0001, 2'b11, 1'b0, 1'b1);
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL flush_slot_ex got %b want 1", c_ex); end
    total++; if (c_ita !== 1'b1) begin bad++; $display("FAIL flush_slot_act got %b want 1", c_ita); end
    ins(1, C_VS, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL flushed_idle got %b want 0", c_ita); end
    total++; if (c_fl !== 4'b0001) begin bad++; $display("FAIL flush_upd got %h want 1", c_fl); end
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL own_cond_vs got %b want 1", c_ex); end
    ins(1, C_EQ, 0, 4'h0, 2'b00);
    total++; if (c_ex !== 1'b0) begin bad++; $display("FAIL own_cond_eq got %b want 0", c_ex); end
  endtask

  task automatic test_async_reset();
    ins(1, C_AL, 0, 4'b0100, 2'b11);
    ins(1, C_AL, 1, 4'b1000, 2'b11);
    it_first = C_EQ; it_mask = 3'b111; it_len = 2'd3;
    ins(1, C_AL, 0, 4'h0, 2'b00, 1'b1);
    ins(1, C_NV, 0, 4'h0, 2'b00);
    total++; if (c_ita !== 1'b1) begin bad++; $display("FAIL pre_rst_act got %b want 1", c_ita); end
    valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (c_ita !== 1'b0) begin bad++; $display("FAIL async_rst_idle got %b want 0", c_ita); end
    total++; if (c_fl !== 4'h0) begin bad++; $display("FAIL async_rst_b0 got %h want 0", c_fl); end
    bank_sel = 1'b1;
    #1;
    total++; if (c_fl !== 4'h0) begin bad++; $display("FAIL async_rst_b1 got %h want 0", c_fl); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pipe();
    ins(0, C_AL, 0, 4'h0, 2'b00);
    ins(1, C_AL, 0, 4'b0100, 2'b11);
    total++; if (p_ex !== 1'b0) begin bad++; $display("FAIL pipe_lat0 got %b want 0", p_ex); end
    total++; if (c_ex !== 1'b1) begin bad++; $display("FAIL comb_al got %b want 1", c_ex); end
    ins(1, C_NV, 0, 4'h0, 2'b00);
    total++; if (p_ex !== 1'b1) begin bad++; $display("FAIL pipe_ex_delayed got %b want 1", p_ex); end
    total++; if (p_ill !== 1'b0) begin bad++; $display("FAIL pipe_ill_early got %b want 0", p_ill); end
    total++; if (p_fl !== 4'b0100) begin bad++; $display("FAIL pipe_flags got %h want 4", p_fl); end
    it_first = C_AL; it_len = 2'd1;
    ins(1, C_AL, 0, 4'h0, 2'b00, 1'b1);
    total++; if (p_ill !== 1'b1) begin bad++; $display("FAIL pipe_ill_delayed got %b want 1", p_ill); end
    total++; if (p_err !== 1'b0) begin bad++; $display("FAIL pipe_err_early got %b want 0", p_err); end
    ins(0, C_AL, 0, 4'h0, 2'b00);
    total++; if (p_err !== 1'b1) begin bad++; $display("FAIL pipe_err_delayed got %b want 1", p_err); end
    total++; if (p_ex !== 1'b1) begin bad++; $display("FAIL pipe_it_ex got %b want 1", p_ex); end
    ins(0, C_AL, 0, 4'h0, 2'b00);
    total++; if (p_ex !== 1'b0) begin bad++; $display("FAIL pipe_idle got %b want 0", p_ex); end
  endtask

  initial begin
    test_reset();
    test_set_flags();
    test_partial();
    test_banks();
    test_it_block();
    test_errors();
    test_flush();
    test_async_reset();
    test_pipe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
